rx_holding_fifo: RTL
====================

RX_HOLDING_FIFO -- requirements
Module: rx_holding_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 3: number of FIFO character slots, excluding the holding stage.
REQ-002 SHALL have parameter CHAR_W, default 8: received character width.
REQ-003 SHALL have a single clock and synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous, active-high.
REQ-004 rx_char  in  CHAR_W  character from the channel receiver shifter.
REQ-005 rx_valid  in  1  one-cycle pulse; rx_char and the error bits are valid.
REQ-006 rx_pe, rx_fe, rx_rb  in  1 each  parity error, framing error and received-break bits for rx_char.
REQ-007 rd  in  1  level, high while the bus reads the receive holding register (cs & rw decoded upstream).
REQ-008 clr_ovr  in  1  one-cycle pulse; clears the overrun flag.
REQ-009 rd_data  out  CHAR_W  registered head character.
REQ-010 st_pe, st_fe, st_rb  out  1 each  error bits of the head character.
REQ-011 rx_rdy  out  1  FIFO non-empty.
REQ-012 ffull  out  1  FIFO holds DEPTH characters; this feeds the interrupt status register.
REQ-013 ovr  out  1  sticky overrun flag.

Function
REQ-014 Storage SHALL be DEPTH FIFO slots plus one holding stage; each entry is {char, pe, fe, rb}.
REQ-015 rx_valid with FIFO not full SHALL push the entry into the FIFO; rx_rdy, ffull and rd_data update on the next clk edge.
REQ-016 rx_valid with FIFO full and holding empty SHALL load the holding stage; ffull stays 1.
REQ-017 rx_valid with FIFO full and holding occupied SHALL overwrite the holding stage and set ovr next cycle; FIFO contents are unchanged.
REQ-018 A pop SHALL occur exactly once per read access: in the cycle rd is sampled 0 having been 1 the previous cycle (falling-edge detect). rd_data SHALL stay stable for the whole access.
REQ-019 A pop on an empty FIFO SHALL have no effect; rd_data SHALL retain its last value.
REQ-020 A pop with the holding stage occupied SHALL move the holding entry into the FIFO in the same cycle; ffull stays 1 and the holding stage becomes empty.
REQ-021 Pop and rx_valid in the same cycle with FIFO full and holding occupied: holding moves into the FIFO, the new entry loads the holding stage, and ovr is NOT set.
REQ-022 Pop and push in the same cycle with FIFO not full: count unchanged; ordering preserved.
REQ-023 rd_data and st_* SHALL update to the new head one cycle after any push into an empty FIFO, or after any pop that leaves the FIFO non-empty.
REQ-024 Occupancy counter width SHALL be clog2(DEPTH+1) bits; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 clr_ovr SHALL clear ovr next cycle. If clr_ovr and a new overrun occur in the same cycle, ovr SHALL be set (set wins).

Reset
REQ-026 rst SHALL empty the FIFO and holding stage, and clear pointers, counter and the rd edge-detect history.
REQ-027 After rst: rd_data = 0, st_* = 0, rx_rdy = 0, ffull = 0, ovr = 0.
REQ-028 rst asserted during a read access SHALL suppress the pop.
REQ-029 rx_valid in a cycle where rst is high SHALL be discarded.

Structure
REQ-030 Package duart_pkg SHALL hold CHAR_W, RX_FIFO_DEPTH = 3 and the rx_entry_t packed struct {char, pe, fe, rb}.
REQ-031 Entry storage SHALL be a sub-module duart_fifo_mem (register array, write port, async read); pointer, holding and flag control logic stays in rx_holding_fifo.

Verification
REQ-032 Reset, then push 0x41 -> rx_rdy = 1 and rd_data = 0x41 one cycle later; ffull = 0.
REQ-033 Push 0x01, 0x02, 0x03 -> ffull = 1. Then push 0x04 -> holding loaded, ovr = 0. Read 4 times (rd high 3 cycles each) -> 0x01..0x04 in order, exactly one pop per access.
REQ-034 Push 0x01..0x05 -> ovr = 1; reads return 0x01, 0x02, 0x03, 0x05. Then pulse clr_ovr -> ovr = 0.
REQ-035 FIFO full, holding = 0x04; pop coincides with rx_valid 0x05 -> ovr stays 0; subsequent reads return 0x02, 0x03, 0x04, 0x05.
REQ-036 Push 0x55 with rx_pe = 1, then 0x66 clean -> st_pe = 1 at head; after pop, st_pe = 0 and rd_data = 0x66.
REQ-037 Assert rst while rd is high with 2 entries stored -> all outputs 0 next cycle; rd falling edge afterwards produces no pop; a read of the empty FIFO returns rd_data = 0.

Source files
------------

// File: rtl/duart_pkg.sv
// Shared DUART definitions: receive character width, receive FIFO depth
// and the receive entry layout.
package duart_pkg;

  localparam int CHAR_W        = 8;
  localparam int RX_FIFO_DEPTH = 3;

  typedef struct packed {
    logic [CHAR_W-1:0] ch;
    logic              pe;
    logic              fe;
    logic              rb;
  } rx_entry_t;

endpackage

// File: rtl/duart_fifo_mem.sv
// Receive FIFO entry storage: register array with one write port and an
// asynchronous read port.
module duart_fifo_mem #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 11,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_holding_fifo.sv
// DUART receive FIFO with an extra holding stage behind it; pops once per
// bus read access on the falling edge of rd, flags sticky overrun.
module rx_holding_fifo
  import duart_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int CHAR_W = duart_pkg::CHAR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] rx_char,
  input  logic              rx_valid,
  input  logic              rx_pe,
  input  logic              rx_fe,
  input  logic              rx_rb,
  input  logic              rd,
  input  logic              clr_ovr,
  output logic [CHAR_W-1:0] rd_data,
  output logic              st_pe,
  output logic              st_fe,
  output logic              st_rb,
  output logic              rx_rdy,
  output logic              ffull,
  output logic              ovr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = CHAR_W + 3;

  typedef struct packed {
    logic [CHAR_W-1:0] ch;
    logic              pe;
    logic              fe;
    logic              rb;
  } entry_t;

  logic [AW-1:0] wptr, rptr, rptr_inc;
  logic [CW-1:0] cnt;
  logic          rd_q, hold_vld;
  entry_t        hold, new_ent, wdata, head, next_head;
  logic [EW-1:0] mem_rdata;
  logic          full, empty, pop, mv_hold, wr_new, we, ld_hold, overrun, load_head;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign new_ent  = '{ch: rx_char, pe: rx_pe, fe: rx_fe, rb: rx_rb};
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign rptr_inc = ptr_inc(rptr);

  // Pop first, then the incoming character: a pop with the holding stage
  // occupied refills the FIFO from it, so a coincident rx_valid lands in
  // the freed holding stage instead of overrunning.
  assign pop      = rd_q & ~rd & ~empty;
  assign mv_hold  = pop & hold_vld;
  assign wr_new   = rx_valid & ~mv_hold & (~full | pop);
  assign we       = mv_hold | wr_new;
  assign wdata    = mv_hold ? hold : new_ent;
  assign ld_hold  = rx_valid & ~wr_new;
  assign overrun  = rx_valid & full & hold_vld & ~pop;

  // New head is the next stored slot, or the entry being written when the
  // FIFO is (or is about to be) down to that single entry.
  assign load_head = (empty & we) | (pop & ((cnt > CW'(1)) | we));
  assign next_head = (pop && (cnt > CW'(1))) ? entry_t'(mem_rdata) : wdata;

  duart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we & ~rst),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr_inc),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      hold_vld <= 1'b0;
      ovr      <= 1'b0;
      head     <= '0;
    end else begin
      rd_q <= rd;
      if (we)  wptr <= ptr_inc(wptr);
      if (pop) rptr <= rptr_inc;
      if (we & ~pop)      cnt <= cnt + 1'b1;
      else if (pop & ~we) cnt <= cnt - 1'b1;
      if (ld_hold)      hold_vld <= 1'b1;
      else if (mv_hold) hold_vld <= 1'b0;
      if (overrun)      ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
      if (load_head) head <= next_head;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_hold) hold <= new_ent;
  end

  assign rd_data = head.ch;
  assign st_pe   = head.pe;
  assign st_fe   = head.fe;
  assign st_rb   = head.rb;
  assign rx_rdy  = ~empty;
  assign ffull   = full;

endmodule
